// File: rtl/piradip_axilite_cmd_manager.sv
// AXI4-Lite manager: one valid/ready command (single 32-bit write or read) becomes one AXI4-Lite
// transaction and one response; strictly one outstanding, in order. Zero-wait write: rsp_valid 3 cycles after accept.
module piradip_axilite_cmd_manager #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  txn_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [31:0]           m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_BRESP,
        S_RD,
        S_RDATA,
        S_RSP
    } state_t;

    state_t                  state_q, state_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    aw_pend_q, aw_pend_d;
    logic                    w_pend_q, w_pend_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic [CNT_WIDTH-1:0]    txn_q, txn_d;
    logic [CNT_WIDTH-1:0]    err_q, err_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            txn_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            txn_q     <= txn_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        txn_d     = txn_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    write_d   = cmd_write;
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    aw_pend_d = cmd_write;
                    w_pend_d  = cmd_write;
                    state_d   = cmd_write ? S_WR : S_RD;
                end
            end
            S_WR: begin
                // AW and W retire independently; move on once both are done
                if (aw_pend_q && m_awready) aw_pend_d = 1'b0;
                if (w_pend_q && m_wready)   w_pend_d  = 1'b0;
                if ((!aw_pend_q || m_awready) && (!w_pend_q || m_wready))
                    state_d = S_BRESP;
            end
            S_BRESP: begin
                if (m_bvalid) begin
                    resp_d  = m_bresp;
                    rdata_d = '0;
                    state_d = S_RSP;
                end
            end
            S_RD: begin
                if (m_arready) state_d = S_RDATA;
            end
            S_RDATA: begin
                if (m_rvalid) begin
                    resp_d  = m_rresp;
                    rdata_d = m_rdata;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    txn_d   = txn_q + CNT_WIDTH'(1);
                    if (resp_q != 2'b00 && err_q != '1)
                        err_d = err_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE) && resetn;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_write = write_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign txn_count = txn_q;
    assign err_count = err_q;

    assign m_awaddr  = addr_q;
    assign m_awprot  = 3'b000;
    assign m_awvalid = (state_q == S_WR) && aw_pend_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = (state_q == S_WR) && w_pend_q;
    assign m_bready  = (state_q == S_BRESP);
    assign m_araddr  = addr_q;
    assign m_arprot  = 3'b000;
    assign m_arvalid = (state_q == S_RD);
    assign m_rready  = (state_q == S_RDATA);

endmodule

// File: tb/tb_piradip_axilite_cmd_manager.sv
// Bench for piradip_axilite_cmd_manager: behavioural AXI4-Lite subordinate with programmable
// ready/valid delays, response scoreboard, and a small counter model (CNT_WIDTH=4 to reach wrap).
module tb_piradip_axilite_cmd_manager;

    localparam int AW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_write;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          busy;
    logic [CW-1:0] txn_count, err_count;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [2:0]    m_awprot, m_arprot;
    logic          m_awvalid, m_awready = 1'b0;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_wvalid, m_wready = 1'b0;
    logic [1:0]    m_bresp = 2'b00;
    logic          m_bvalid = 1'b0, m_bready;
    logic          m_arvalid, m_arready = 1'b0;
    logic [31:0]   m_rdata = '0;
    logic [1:0]    m_rresp = 2'b00;
    logic          m_rvalid = 1'b0, m_rready;

    always #5 clk = ~clk;

    piradip_axilite_cmd_manager #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
        .txn_count(txn_count), .err_count(err_count),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    typedef struct packed { logic write; logic [31:0] rdata; logic [1:0] resp; } rsp_t;
    typedef struct packed { logic [31:0] rdata; logic [1:0] resp; } sub_t;

    rsp_t exp_q[$];
    rsp_t got_q[$];
    sub_t sub_q[$];
    int   acc_q[$];
    int   chk_cnt = 0, pass_cnt = 0;

    // ---------------- monitor (samples at the active edge, pre-update values) ----------------
    int          cyc = 0;
    int          aw_cyc = 0, w_cyc = 0, b_cyc = 0, ar_cyc = 0, rsp_cyc = 0;
    int          b_hs = 0, awv_cyc = 0, wv_cyc = 0, viol = 0, rdy_busy = 0;
    logic [31:0] aw_addr_seen = '0, w_data_seen = '0, ar_addr_seen = '0;
    logic [3:0]  w_strb_seen = '0;
    logic [2:0]  prot_seen = '0;
    logic        p_awv = 1'b0, p_wv = 1'b0, p_arv = 1'b0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
    logic [3:0]  p_wstrb = '0;

    always @(posedge clk) begin
        if (!resetn) begin
            p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
            if (m_awvalid) awv_cyc++;
            if (m_wvalid)  wv_cyc++;
            // a pending VALID must still be up with an unchanged payload
            if (p_awv && (!m_awvalid || m_awaddr !== p_awaddr)) viol++;
            if (p_wv && (!m_wvalid || m_wdata !== p_wdata || m_wstrb !== p_wstrb)) viol++;
            if (p_arv && (!m_arvalid || m_araddr !== p_araddr)) viol++;
            if (m_awvalid && m_awready) begin
                aw_cyc = cyc; aw_addr_seen = m_awaddr; prot_seen = m_awprot;
            end
            if (m_wvalid && m_wready) begin
                w_cyc = cyc; w_data_seen = m_wdata; w_strb_seen = m_wstrb;
            end
            if (m_arvalid && m_arready) begin
                ar_cyc = cyc; ar_addr_seen = m_araddr;
            end
            if (m_bvalid && m_bready) begin b_hs++; b_cyc = cyc; end
            if (rsp_valid && rsp_ready) begin
                got_q.push_back(rsp_t'({rsp_write, rsp_rdata, rsp_resp}));
                rsp_cyc = cyc;
            end
            if (cmd_ready && busy) rdy_busy++;
            p_awv = m_awvalid && !m_awready; p_awaddr = m_awaddr;
            p_wv  = m_wvalid && !m_wready;   p_wdata = m_wdata; p_wstrb = m_wstrb;
            p_arv = m_arvalid && !m_arready; p_araddr = m_araddr;
        end
        cyc++;
    end

    // ---------------- subordinate model (decides at the falling edge) ----------------
    int   aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    int   aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    int   s_aw = 0, s_w = 0, s_ar = 0, s_b = 0, s_r = 0;
    logic sv_awv = 1'b0, sv_wv = 1'b0, sv_arv = 1'b0, sv_bry = 1'b0, sv_rry = 1'b0;
    sub_t se;

    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
            m_bvalid = 1'b0; m_rvalid = 1'b0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
            s_aw = 0; s_w = 0; s_ar = 0; s_b = 0; s_r = 0;
            sv_awv = 1'b0; sv_wv = 1'b0; sv_arv = 1'b0; sv_bry = 1'b0; sv_rry = 1'b0;
            sub_q.delete();
        end else begin
            if (m_awready && sv_awv) begin s_aw++; aw_wait = 0; end
            if (m_wready && sv_wv)   begin s_w++;  w_wait = 0;  end
            if (m_arready && sv_arv) begin s_ar++; ar_wait = 0; end
            if (m_bvalid && sv_bry)  begin s_b++;  m_bvalid = 1'b0; b_wait = 0; end
            if (m_rvalid && sv_rry)  begin s_r++;  m_rvalid = 1'b0; r_wait = 0; end
            m_awready = m_awvalid && (aw_wait >= aw_delay);
            if (m_awvalid && !m_awready) aw_wait++;
            m_wready = m_wvalid && (w_wait >= w_delay);
            if (m_wvalid && !m_wready) w_wait++;
            m_arready = m_arvalid && (ar_wait >= ar_delay);
            if (m_arvalid && !m_arready) ar_wait++;
            if (!m_bvalid && s_aw > s_b && s_w > s_b) begin
                if (b_wait >= b_delay) begin
                    se = (sub_q.size() > 0) ? sub_q.pop_front() : sub_t'(0);
                    m_bvalid = 1'b1; m_bresp = se.resp;
                end else b_wait++;
            end
            if (!m_rvalid && s_ar > s_r) begin
                if (r_wait >= r_delay) begin
                    se = (sub_q.size() > 0) ? sub_q.pop_front() : sub_t'(0);
                    m_rvalid = 1'b1; m_rdata = se.rdata; m_rresp = se.resp;
                end else r_wait++;
            end
            sv_awv = m_awvalid; sv_wv = m_wvalid; sv_arv = m_arvalid;
            sv_bry = m_bready;  sv_rry = m_rready;
        end
    end

    // ---------------- stimulus ----------------
    // Expected response: writes return zero rdata and the subordinate's BRESP.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] sub_rdata, input logic [1:0] sub_resp);
        int n = 0;
        @(negedge clk);
        sub_q.push_back(sub_t'({sub_rdata, sub_resp}));
        exp_q.push_back(rsp_t'({w, (w ? 32'h0 : sub_rdata), sub_resp}));
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (got_q.size() < n && k < 500) begin @(negedge clk); k++; end
    endtask

    task automatic test_reset;
        #2 resetn = 1'b0;
        #1;
        chk_cnt++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); else pass_cnt++;
        chk_cnt++; if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0)
            $display("FAIL reset_axi got %b exp 00000", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}); else pass_cnt++;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_rel_cmd_ready got %b exp 1", cmd_ready); else pass_cnt++;
        chk_cnt++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL reset_rsp_busy got %b exp 00", {rsp_valid, busy}); else pass_cnt++;
        chk_cnt++; if ({txn_count, err_count} !== 8'h00) $display("FAIL reset_counts got %h exp 00", {txn_count, err_count}); else pass_cnt++;
    endtask

    task automatic test_write_zero_wait;
        rsp_t g, e;
        int   a;
        acc_q.delete();
        issue(1'b1, 32'h8, 32'h5, 4'hF, 32'h0, 2'b00);
        wait_rsp(1);
        a = (acc_q.size() > 0) ? acc_q[0] : -100;
        chk_cnt++; if (aw_cyc !== a + 1) $display("FAIL wr_aw_lat got %0d exp %0d", aw_cyc - a, 1); else pass_cnt++;
        chk_cnt++; if (w_cyc !== a + 1) $display("FAIL wr_w_lat got %0d exp %0d", w_cyc - a, 1); else pass_cnt++;
        chk_cnt++; if (b_cyc !== a + 2) $display("FAIL wr_b_lat got %0d exp %0d", b_cyc - a, 2); else pass_cnt++;
        chk_cnt++; if (rsp_cyc !== a + 3) $display("FAIL wr_rsp_lat got %0d exp %0d", rsp_cyc - a, 3); else pass_cnt++;
        chk_cnt++; if ({aw_addr_seen, w_data_seen, w_strb_seen, prot_seen} !== {32'h8, 32'h5, 4'hF, 3'b000})
            $display("FAIL wr_payload got %h %h %h %h exp 8 5 f 0", aw_addr_seen, w_data_seen, w_strb_seen, prot_seen); else pass_cnt++;
        chk_cnt++; if (txn_count !== 4'd1) $display("FAIL wr_txn got %0d exp 1", txn_count); else pass_cnt++;
        chk_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL wr_rsp_count got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            chk_cnt++; if (g !== e) $display("FAIL wr_rsp got %h exp %h", g, e); else pass_cnt++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_aw_delay;
        rsp_t g, e;
        int   awv0, wv0, b0;
        awv0 = awv_cyc; wv0 = wv_cyc; b0 = b_hs;
        aw_delay = 3;
        issue(1'b1, 32'h10, 32'hA5A5_0001, 4'h3, 32'h0, 2'b00);
        wait_rsp(1);
        aw_delay = 0;
        chk_cnt++; if (awv_cyc - awv0 !== 4) $display("FAIL awdly_awvalid_cycles got %0d exp 4", awv_cyc - awv0); else pass_cnt++;
        chk_cnt++; if (wv_cyc - wv0 !== 1) $display("FAIL awdly_wvalid_cycles got %0d exp 1", wv_cyc - wv0); else pass_cnt++;
        chk_cnt++; if (b_hs - b0 !== 1) $display("FAIL awdly_b_count got %0d exp 1", b_hs - b0); else pass_cnt++;
        chk_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL awdly_rsp_count got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            chk_cnt++; if (g !== e) $display("FAIL awdly_rsp got %h exp %h", g, e); else pass_cnt++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_read_delay;
        rsp_t g, e;
        r_delay = 5;
        issue(1'b0, 32'h4, 32'hFFFF_FFFF, 4'hF, 32'hDEAD_BEEF, 2'b00);
        wait_rsp(1);
        r_delay = 0;
        chk_cnt++; if (ar_addr_seen !== 32'h4) $display("FAIL rd_araddr got %h exp 4", ar_addr_seen); else pass_cnt++;
        chk_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL rd_rsp_count got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            chk_cnt++; if (g !== e) $display("FAIL rd_rsp got %h exp %h", g, e); else pass_cnt++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_slverr;
        rsp_t g, e;
        int   rb0;
        rb0 = rdy_busy;
        b_delay = 2;
        issue(1'b1, 32'h40, 32'h1234, 4'hF, 32'h0, 2'b10);
        wait_rsp(1);
        b_delay = 0;
        chk_cnt++; if (err_count !== 4'd1) $display("FAIL slverr_err got %0d exp 1", err_count); else pass_cnt++;
        chk_cnt++; if (txn_count !== 4'd4) $display("FAIL slverr_txn got %0d exp 4", txn_count); else pass_cnt++;
        chk_cnt++; if (rdy_busy - rb0 !== 0) $display("FAIL slverr_cmd_ready_busy got %0d exp 0", rdy_busy - rb0); else pass_cnt++;
        chk_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL slverr_rsp_count got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            chk_cnt++; if (g !== e) $display("FAIL slverr_rsp got %h exp %h", g, e); else pass_cnt++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_rsp_stall;
        rsp_t g, e;
        int   k = 0, held_bad = 0, act = 0, crdy = 0;
        rsp_ready = 1'b0;
        issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h1234_5678, 2'b00);
        while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
        chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL stall_rsp_valid got %b exp 1", rsp_valid); else pass_cnt++;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== 32'h1234_5678 || rsp_write !== 1'b0) held_bad++;
            if (m_awvalid || m_wvalid || m_arvalid || m_bready || m_rready) act++;
            if (cmd_ready) crdy++;
        end
        chk_cnt++; if (held_bad !== 0) $display("FAIL stall_hold got %0d exp 0", held_bad); else pass_cnt++;
        chk_cnt++; if (act !== 0) $display("FAIL stall_axi_activity got %0d exp 0", act); else pass_cnt++;
        chk_cnt++; if (crdy !== 0) $display("FAIL stall_cmd_ready got %0d exp 0", crdy); else pass_cnt++;
        rsp_ready = 1'b1;
        wait_rsp(1);
        @(negedge clk);
        chk_cnt++; if (txn_count !== 4'd5) $display("FAIL stall_txn got %0d exp 5", txn_count); else pass_cnt++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            chk_cnt++; if (g !== e) $display("FAIL stall_rsp got %h exp %h", g, e); else pass_cnt++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid;
        int k = 0;
        aw_delay = 20;
        issue(1'b1, 32'h80, 32'hCAFE, 4'hF, 32'h0, 2'b00);
        while (!m_awvalid && k < 50) begin @(negedge clk); k++; end
        #2 resetn = 1'b0;
        #1;
        chk_cnt++; if ({m_awvalid, m_wvalid, busy, rsp_valid} !== 4'b0)
            $display("FAIL rstmid_valids got %b exp 0000", {m_awvalid, m_wvalid, busy, rsp_valid}); else pass_cnt++;
        chk_cnt++; if ({txn_count, err_count} !== 8'h00) $display("FAIL rstmid_counts got %h exp 00", {txn_count, err_count}); else pass_cnt++;
        chk_cnt++; if (cmd_ready !== 1'b0) $display("FAIL rstmid_cmd_ready_low got %b exp 0", cmd_ready); else pass_cnt++;
        exp_q.delete();
        aw_delay = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rstmid_cmd_ready got %b exp 1", cmd_ready); else pass_cnt++;
        repeat (5) @(negedge clk);
        chk_cnt++; if (got_q.size() !== 0) $display("FAIL rstmid_dropped got %0d exp 0", got_q.size()); else pass_cnt++;
        got_q.delete();
    endtask

    // Randomised mix with a zero-wait subordinate: accepts must land every 4 cycles.
    task automatic test_back_to_back(inout logic [CW-1:0] txn_m, inout logic [CW-1:0] err_m);
        rsp_t       g, e;
        int         bad_gap = 0;
        logic [1:0] r;
        acc_q.delete();
        for (int i = 0; i < 10; i++) begin
            r = 2'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom, r);
            txn_m = txn_m + 1'b1;
            if (r != 2'b00 && err_m != {CW{1'b1}}) err_m = err_m + 1'b1;
        end
        wait_rsp(10);
        @(negedge clk);
        for (int i = 1; i < acc_q.size(); i++) if (acc_q[i] - acc_q[i-1] != 4) bad_gap++;
        chk_cnt++; if (acc_q.size() !== 10 || bad_gap !== 0)
            $display("FAIL b2b_accept_spacing got %0d accepts %0d bad gaps exp 10 0", acc_q.size(), bad_gap); else pass_cnt++;
        chk_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL b2b_rsp_count got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            chk_cnt++; if (g !== e) $display("FAIL b2b_rsp got %h exp %h", g, e); else pass_cnt++;
        end
        exp_q.delete(); got_q.delete();
        chk_cnt++; if (txn_count !== txn_m) $display("FAIL b2b_txn got %0d exp %0d", txn_count, txn_m); else pass_cnt++;
        chk_cnt++; if (err_count !== err_m) $display("FAIL b2b_err got %0d exp %0d", err_count, err_m); else pass_cnt++;
    endtask

    task automatic test_counters(inout logic [CW-1:0] txn_m, inout logic [CW-1:0] err_m);
        for (int i = 0; i < 20; i++) begin
            issue(1'b1, 32'h100 + 32'(i), 32'(i), 4'hF, 32'h0, 2'b10);
            txn_m = txn_m + 1'b1;
            if (err_m != {CW{1'b1}}) err_m = err_m + 1'b1;
        end
        wait_rsp(20);
        @(negedge clk);
        chk_cnt++; if (got_q.size() !== 20) $display("FAIL cnt_rsp_count got %0d exp 20", got_q.size()); else pass_cnt++;
        chk_cnt++; if (txn_count !== txn_m) $display("FAIL cnt_txn_wrap got %0d exp %0d", txn_count, txn_m); else pass_cnt++;
        chk_cnt++; if (err_count !== 4'hF) $display("FAIL cnt_err_sat got %0d exp 15", err_count); else pass_cnt++;
        chk_cnt++; if (viol !== 0) $display("FAIL axi_valid_stability got %0d exp 0", viol); else pass_cnt++;
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] txn_m, err_m;
        test_reset();
        test_write_zero_wait();
        test_aw_delay();
        test_read_delay();
        test_slverr();
        test_rsp_stall();
        test_reset_mid();
        txn_m = '0;
        err_m = '0;
        test_back_to_back(txn_m, err_m);
        test_counters(txn_m, err_m);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
